uart_tx_result: RTL and testbench

UART_TX_RESULT -- requirements
Module: uart_tx_result

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_byte_fifo.sv | 48 ++++
 rtl/uart_tx_result.sv | 144 ++++++++++++++
 tb/tb_uart_tx_result.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// The ST_PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Cycles per serial bit, truncated.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with push/pop handshake; head is the oldest entry.
// Pointers carry one extra wrap bit so full and empty are pointer-derived.
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; empty/full come from the
    // pointers, so a stale entry is never presented as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_result.sv
// Result-byte UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_result #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       uart_tx_pin,
    output logic       busy
);

    import uart_pkg::*;

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          ready_en;
    logic          bit_done;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    uart_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(in_data),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ready_en holds in_ready low until the first edge after reset release.
    assign in_ready = ready_en && !fifo_full;
    assign push     = in_valid && in_ready;
    assign bit_done = (baud_cnt == BAUD_LAST);
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    // Popping at the end of STOP chains frames with no idle gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && (state == ST_IDLE || (state == ST_STOP && bit_done)))
            pop = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            ready_en    <= 1'b0;
            uart_tx_pin <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            if (state != ST_IDLE)
                baud_cnt <= bit_done ? '0 : baud_cnt + BAUD_ONE;
            if (pop) begin
                shift <= fifo_head;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^fifo_head;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state       <= ST_START;
                        uart_tx_pin <= START_BIT;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state       <= ST_DATA;
                        uart_tx_pin <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state       <= ST_PARITY;
                            uart_tx_pin <= parity_bit;
`else
                            state       <= ST_STOP;
                            uart_tx_pin <= STOP_BIT;
`endif
                        end else begin
                            bit_cnt     <= bit_cnt + 3'd1;
                            shift       <= {1'b0, shift[7:1]};
                            uart_tx_pin <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state       <= ST_STOP;
                        uart_tx_pin <= STOP_BIT;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state       <= ST_START;
                            uart_tx_pin <= START_BIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    uart_tx_pin <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_result.sv
// Self-checking bench for uart_tx_result: cycle model of the serial line,
// mid-bit sampling receiver, and directed scenarios with literal expectations.
module tb_uart_tx_result;

    localparam int CPB   = 50000000 / 115200;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB          = 11;
    localparam int BUSY_ONE    = 4775;
    localparam int FULL_WAIT   = 4771;
`else
    localparam int NB          = 10;
    localparam int BUSY_ONE    = 4341;
    localparam int FULL_WAIT   = 4337;
`endif
    localparam int FRAME_CYC = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       uart_tx_pin;
    logic       busy;

    int checks = 0;
    int failures = 0;

    uart_tx_result dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .uart_tx_pin(uart_tx_pin),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit slot idx within the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Model: a waiting queue plus the byte on the wire and its elapsed cycle count.
    logic [7:0] mq[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    bit         m_ready_en = 1'b0;
    bit         m_acc;
    int         m_t = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_active   = 1'b0;
            m_t        = 0;
            m_ready_en = 1'b0;
        end else begin
            m_acc = m_ready_en && (mq.size() < DEPTH) && in_valid;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME_CYC) m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (m_acc) mq.push_back(in_data);
            m_ready_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("line", uart_tx_pin, m_active ? frame_bit(m_cur, m_t / CPB) : 1'b1);
        check("busy", busy, m_active || (mq.size() != 0));
        check("in_ready", in_ready, m_ready_en && (mq.size() < DEPTH));
    end

    // Behavioural receiver sampling at mid-bit.
    logic [7:0]  rxq[$];
    logic [10:0] rx_bits = '0;
    int          frame_err = 0;
    int          par_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst && uart_tx_pin === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                rx_bits[0] = uart_tx_pin;
                for (int k = 1; k < NB; k++) begin
                    repeat (CPB) @(negedge clk);
                    rx_bits[k] = uart_tx_pin;
                end
                if (rx_bits[0] !== 1'b0 || rx_bits[NB-1] !== 1'b1) frame_err++;
`ifdef UART_TX_PARITY_EN
                if (rx_bits[9] !== ^rx_bits[8:1]) par_err++;
`endif
                rxq.push_back(rx_bits[8:1]);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check("push_accepted", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
        @(negedge clk);
    endtask

    int         seq_5a [NB];
    logic [5:0] rdy;
    int         wait_n;
    int         bc;

    initial begin
`ifdef UART_TX_PARITY_EN
        seq_5a = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
`else
        seq_5a = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
`endif
        #5 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pin", uart_tx_pin, 1'b1);
        check("rst_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_edge", in_ready, 1'b1);

        // Single byte 0x5A: latency, frame duration, bit sequence.
        rxq.delete();
        push_byte(8'h5A);
        bc = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (n == 0) check("lat_before_start", uart_tx_pin, 1'b1);
            if (n == 1) check("lat_start_low", uart_tx_pin, 1'b0);
            if (!busy) break;
            bc++;
        end
        check("busy_cycles_5a", bc, BUSY_ONE);
        check("rx_count_5a", rxq.size(), 1);
        if (rxq.size() > 0) check("rx_byte_5a", rxq[0], 8'h5A);
        for (int k = 0; k < NB; k++)
            check($sformatf("bit%0d_5a", k), rx_bits[k], seq_5a[k]);

        // Six bytes on consecutive cycles: FIFO fills, sixth waits for a slot.
        rxq.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            rdy[i]   = in_ready;
        end
        wait_n = 0;
        while (!in_ready && wait_n < 20000) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ready_pattern", rdy, 6'b011111);
        check("full_wait_cycles", wait_n, FULL_WAIT);
        wait_idle();
        check("rx_count_burst", rxq.size(), 6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            check($sformatf("rx_burst%0d", i), rxq[i], 8'h10 + 8'(i));

`ifdef UART_TX_PARITY_EN
        rxq.delete();
        push_byte(8'h07);
        wait_idle();
        check("parity_07", rx_bits[9], 1'b1);
        check("stop_07", rx_bits[10], 1'b1);
        push_byte(8'h03);
        wait_idle();
        check("parity_03", rx_bits[9], 1'b0);
        check("par_err", par_err, 0);
`endif

        // Reset in the middle of the 4th data bit of 0xFF with two bytes queued.
        push_byte(8'hFF);
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (1951) @(posedge clk);
        #1;
        check("busy_midframe", busy, 1'b1);
        #4;
        rst = 1'b0;
        #1;
        check("abort_pin", uart_tx_pin, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", in_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("release_ready_high", in_ready, 1'b1);
        repeat (3000) @(negedge clk);
        check("post_reset_pin", uart_tx_pin, 1'b1);
        check("post_reset_busy", busy, 1'b0);

        // Loopback of 10,20,...,90.
        rxq.delete();
        frame_err = 0;
        par_err   = 0;
        for (int v = 1; v <= 9; v++) push_byte(8'(v * 10));
        wait_idle();
        check("rx_count_loop", rxq.size(), 9);
        for (int v = 1; v <= 9 && v <= rxq.size(); v++)
            check($sformatf("rx_loop%0d", v), rxq[v-1], 8'(v * 10));
        check("frame_err", frame_err, 0);
        check("loop_par_err", par_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #8000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
